// File: rtl/lsu_mxu_pkg.sv
// Shared types and defaults for the LSU-side MXU driver.
// Holds the job FSM state type plus the pooling/activation field encodings.
package lsu_mxu_pkg;

  localparam int NROW_DEF = 16;
  localparam int IW_DEF   = 128;
  localparam int OW_DEF   = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FEED,
    ST_CLR,
    ST_WAIT,
    ST_DRAIN
  } state_t;

  localparam logic [1:0] POOL_2X2 = 2'd0;
  localparam logic [1:0] POOL_3X3 = 2'd1;
  localparam logic [1:0] POOL_4X4 = 2'd2;
  localparam logic [1:0] POOL_8X8 = 2'd3;

  localparam logic [1:0] ACT_RELU    = 2'd0;
  localparam logic [1:0] ACT_RELU6   = 2'd1;
  localparam logic [1:0] ACT_SIGMOID = 2'd2;
  localparam logic [1:0] ACT_TANH    = 2'd3;

endpackage

// File: rtl/lsu_mxu_res_buf.sv
// Result snapshot buffer: captures all result rows in one cycle, then
// replays them one row per accepted beat on the res_* handshake.
module lsu_mxu_res_buf
  import lsu_mxu_pkg::*;
#(
  parameter int NROW = NROW_DEF,
  parameter int IW   = IW_DEF,
  parameter int OW   = OW_DEF,
  parameter int RW   = $clog2(NROW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          capture,
  input  logic          int16,
  input  logic [IW-1:0] int8_rows  [NROW],
  input  logic [OW-1:0] int16_rows [NROW],
  output logic          res_vld,
  input  logic          res_rdy,
  output logic [RW-1:0] res_row,
  output logic [OW-1:0] res_data,
  output logic          done
);

  logic [OW-1:0] snap [NROW];
  logic          last_row;

  assign last_row = (res_row == RW'(NROW - 1));
  assign done     = res_vld & res_rdy & last_row;
  assign res_data = snap[res_row];

  // int8 rows are zero-extended so the result bus width never changes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NROW; i++) snap[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < NROW; i++)
        snap[i] <= int16 ? int16_rows[i] : OW'(int8_rows[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_vld <= 1'b0;
      res_row <= '0;
    end else if (capture) begin
      res_vld <= 1'b1;
      res_row <= '0;
    end else if (res_vld && res_rdy) begin
      res_vld <= !last_row;
      res_row <= last_row ? '0 : res_row + RW'(1);
    end
  end

endmodule

// File: rtl/lsu_mxu_drv.sv
// LSU driver for the MXU top port: per command, feeds NROW operand rows (or a
// clear), waits for results, snapshots them and replays them row by row.
module lsu_mxu_drv
  import lsu_mxu_pkg::*;
#(
  parameter int NROW = NROW_DEF,
  parameter int IW   = IW_DEF,
  parameter int OW   = OW_DEF,
  parameter int RW   = $clog2(NROW)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_vld,
  output logic            cmd_rdy,
  input  logic            cmd_clr,
  input  logic            cmd_int16,
  input  logic            cmd_pool_vld,
  input  logic [1:0]      cmd_pool_size,
  input  logic            cmd_act_vld,
  input  logic [1:0]      cmd_act_type,
  input  logic            opd_vld,
  output logic            opd_rdy,
  input  logic [IW-1:0]   opd_iram_pld,
  input  logic [IW-1:0]   opd_wram_pld,
  output logic            lsu_top_vld,
  output logic            lsu_top_clr,
  output logic [NROW-1:0] lsu_top_iram_vld,
  output logic [IW-1:0]   lsu_top_iram_pld,
  output logic [NROW-1:0] lsu_top_wram_vld,
  output logic [IW-1:0]   lsu_top_wram_pld,
  output logic            lsu_top_pool_vld,
  output logic [1:0]      lsu_top_pool_size,
  output logic            lsu_top_act_vld,
  output logic [1:0]      lsu_top_act_type,
  output logic            lsu_top_wfi,
  input  logic            top_lsu_rdy,
  input  logic            top_lsu_data_rdy,
  input  logic [IW-1:0]   top_lsu_int8_row0_data,
  input  logic [IW-1:0]   top_lsu_int8_row1_data,
  input  logic [IW-1:0]   top_lsu_int8_row2_data,
  input  logic [IW-1:0]   top_lsu_int8_row3_data,
  input  logic [IW-1:0]   top_lsu_int8_row4_data,
  input  logic [IW-1:0]   top_lsu_int8_row5_data,
  input  logic [IW-1:0]   top_lsu_int8_row6_data,
  input  logic [IW-1:0]   top_lsu_int8_row7_data,
  input  logic [IW-1:0]   top_lsu_int8_row8_data,
  input  logic [IW-1:0]   top_lsu_int8_row9_data,
  input  logic [IW-1:0]   top_lsu_int8_row10_data,
  input  logic [IW-1:0]   top_lsu_int8_row11_data,
  input  logic [IW-1:0]   top_lsu_int8_row12_data,
  input  logic [IW-1:0]   top_lsu_int8_row13_data,
  input  logic [IW-1:0]   top_lsu_int8_row14_data,
  input  logic [IW-1:0]   top_lsu_int8_row15_data,
  input  logic [OW-1:0]   top_lsu_int16_row0_data,
  input  logic [OW-1:0]   top_lsu_int16_row1_data,
  input  logic [OW-1:0]   top_lsu_int16_row2_data,
  input  logic [OW-1:0]   top_lsu_int16_row3_data,
  input  logic [OW-1:0]   top_lsu_int16_row4_data,
  input  logic [OW-1:0]   top_lsu_int16_row5_data,
  input  logic [OW-1:0]   top_lsu_int16_row6_data,
  input  logic [OW-1:0]   top_lsu_int16_row7_data,
  input  logic [OW-1:0]   top_lsu_int16_row8_data,
  input  logic [OW-1:0]   top_lsu_int16_row9_data,
  input  logic [OW-1:0]   top_lsu_int16_row10_data,
  input  logic [OW-1:0]   top_lsu_int16_row11_data,
  input  logic [OW-1:0]   top_lsu_int16_row12_data,
  input  logic [OW-1:0]   top_lsu_int16_row13_data,
  input  logic [OW-1:0]   top_lsu_int16_row14_data,
  input  logic [OW-1:0]   top_lsu_int16_row15_data,
  output logic            res_vld,
  input  logic            res_rdy,
  output logic [RW-1:0]   res_row,
  output logic [OW-1:0]   res_data
);

  state_t state, nxt;

  logic [RW-1:0]   k;
  logic            beat_vld, beat_last, last_row;
  logic            cmd_acc, opd_acc, capture, res_done;
  logic [NROW-1:0] row_sel;

  logic            job_int16, job_pool_vld, job_act_vld;
  logic [1:0]      job_pool_size, job_act_type;

  logic [IW-1:0]   int8_rows  [NROW];
  logic [OW-1:0]   int16_rows [NROW];

  assign int8_rows[0]   = top_lsu_int8_row0_data;
  assign int8_rows[1]   = top_lsu_int8_row1_data;
  assign int8_rows[2]   = top_lsu_int8_row2_data;
  assign int8_rows[3]   = top_lsu_int8_row3_data;
  assign int8_rows[4]   = top_lsu_int8_row4_data;
  assign int8_rows[5]   = top_lsu_int8_row5_data;
  assign int8_rows[6]   = top_lsu_int8_row6_data;
  assign int8_rows[7]   = top_lsu_int8_row7_data;
  assign int8_rows[8]   = top_lsu_int8_row8_data;
  assign int8_rows[9]   = top_lsu_int8_row9_data;
  assign int8_rows[10]  = top_lsu_int8_row10_data;
  assign int8_rows[11]  = top_lsu_int8_row11_data;
  assign int8_rows[12]  = top_lsu_int8_row12_data;
  assign int8_rows[13]  = top_lsu_int8_row13_data;
  assign int8_rows[14]  = top_lsu_int8_row14_data;
  assign int8_rows[15]  = top_lsu_int8_row15_data;
  assign int16_rows[0]  = top_lsu_int16_row0_data;
  assign int16_rows[1]  = top_lsu_int16_row1_data;
  assign int16_rows[2]  = top_lsu_int16_row2_data;
  assign int16_rows[3]  = top_lsu_int16_row3_data;
  assign int16_rows[4]  = top_lsu_int16_row4_data;
  assign int16_rows[5]  = top_lsu_int16_row5_data;
  assign int16_rows[6]  = top_lsu_int16_row6_data;
  assign int16_rows[7]  = top_lsu_int16_row7_data;
  assign int16_rows[8]  = top_lsu_int16_row8_data;
  assign int16_rows[9]  = top_lsu_int16_row9_data;
  assign int16_rows[10] = top_lsu_int16_row10_data;
  assign int16_rows[11] = top_lsu_int16_row11_data;
  assign int16_rows[12] = top_lsu_int16_row12_data;
  assign int16_rows[13] = top_lsu_int16_row13_data;
  assign int16_rows[14] = top_lsu_int16_row14_data;
  assign int16_rows[15] = top_lsu_int16_row15_data;

  assign cmd_rdy     = (state == ST_IDLE);
  assign cmd_acc     = cmd_vld & cmd_rdy;
  assign lsu_top_vld = beat_vld | (state == ST_CLR);
  assign lsu_top_clr = (state == ST_CLR);
  assign lsu_top_wfi = (state == ST_WAIT);
  assign capture     = (state == ST_WAIT) & top_lsu_data_rdy;
  assign last_row    = (k == RW'(NROW - 1));
  assign row_sel     = NROW'(1) << k;

  // skid register refills in the cycle it drains, except behind the last row
  assign opd_rdy = (state == ST_FEED) & (!beat_vld | (top_lsu_rdy & !beat_last));
  assign opd_acc = opd_vld & opd_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (cmd_acc) nxt = cmd_clr ? ST_CLR : ST_FEED;
      ST_CLR:   if (top_lsu_rdy) nxt = ST_IDLE;
      ST_FEED:  if (beat_vld && beat_last && top_lsu_rdy) nxt = ST_WAIT;
      ST_WAIT:  if (top_lsu_data_rdy) nxt = ST_DRAIN;
      ST_DRAIN: if (res_done) nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job_int16     <= 1'b0;
      job_pool_vld  <= 1'b0;
      job_pool_size <= POOL_2X2;
      job_act_vld   <= 1'b0;
      job_act_type  <= ACT_RELU;
    end else if (cmd_acc) begin
      job_int16     <= cmd_int16;
      job_pool_vld  <= cmd_pool_vld;
      job_pool_size <= cmd_pool_size;
      job_act_vld   <= cmd_act_vld;
      job_act_type  <= cmd_act_type;
    end
  end

  // pool/act ride only on the final row so the top applies them once per job
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k                 <= '0;
      beat_vld          <= 1'b0;
      beat_last         <= 1'b0;
      lsu_top_iram_vld  <= '0;
      lsu_top_wram_vld  <= '0;
      lsu_top_iram_pld  <= '0;
      lsu_top_wram_pld  <= '0;
      lsu_top_pool_vld  <= 1'b0;
      lsu_top_pool_size <= POOL_2X2;
      lsu_top_act_vld   <= 1'b0;
      lsu_top_act_type  <= ACT_RELU;
    end else if (opd_acc) begin
      k                 <= last_row ? '0 : k + RW'(1);
      beat_vld          <= 1'b1;
      beat_last         <= last_row;
      lsu_top_iram_vld  <= row_sel;
      lsu_top_wram_vld  <= row_sel;
      lsu_top_iram_pld  <= opd_iram_pld;
      lsu_top_wram_pld  <= opd_wram_pld;
      lsu_top_pool_vld  <= last_row & job_pool_vld;
      lsu_top_pool_size <= last_row ? job_pool_size : POOL_2X2;
      lsu_top_act_vld   <= last_row & job_act_vld;
      lsu_top_act_type  <= last_row ? job_act_type : ACT_RELU;
    end else if (beat_vld && top_lsu_rdy) begin
      beat_vld          <= 1'b0;
      beat_last         <= 1'b0;
      lsu_top_iram_vld  <= '0;
      lsu_top_wram_vld  <= '0;
      lsu_top_iram_pld  <= '0;
      lsu_top_wram_pld  <= '0;
      lsu_top_pool_vld  <= 1'b0;
      lsu_top_pool_size <= POOL_2X2;
      lsu_top_act_vld   <= 1'b0;
      lsu_top_act_type  <= ACT_RELU;
    end
  end

  lsu_mxu_res_buf #(
    .NROW(NROW),
    .IW  (IW),
    .OW  (OW),
    .RW  (RW)
  ) u_res_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture   (capture),
    .int16     (job_int16),
    .int8_rows (int8_rows),
    .int16_rows(int16_rows),
    .res_vld   (res_vld),
    .res_rdy   (res_rdy),
    .res_row   (res_row),
    .res_data  (res_data),
    .done      (res_done)
  );

endmodule

// File: tb/tb_lsu_mxu_drv.sv
// Scoreboard bench for lsu_mxu_drv: a job-level model queues expected top beats
// and result rows; a monitor pops and compares whenever the DUT transfers.
module tb_lsu_mxu_drv;

  localparam int NROW = 16;
  localparam int IW   = 128;
  localparam int OW   = 256;
  localparam int RW   = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmd_vld, cmd_rdy, cmd_clr, cmd_int16, cmd_pool_vld, cmd_act_vld;
  logic [1:0]      cmd_pool_size, cmd_act_type;
  logic            opd_vld, opd_rdy;
  logic [IW-1:0]   opd_iram_pld, opd_wram_pld;
  logic            lsu_top_vld, lsu_top_clr, lsu_top_pool_vld, lsu_top_act_vld, lsu_top_wfi;
  logic [NROW-1:0] lsu_top_iram_vld, lsu_top_wram_vld;
  logic [IW-1:0]   lsu_top_iram_pld, lsu_top_wram_pld;
  logic [1:0]      lsu_top_pool_size, lsu_top_act_type;
  logic            top_lsu_rdy, top_lsu_data_rdy;
  logic [IW-1:0]   r8  [NROW];
  logic [OW-1:0]   r16 [NROW];
  logic            res_vld, res_rdy;
  logic [RW-1:0]   res_row;
  logic [OW-1:0]   res_data;

  typedef struct packed {
    logic            clr;
    logic [NROW-1:0] isel;
    logic [NROW-1:0] wsel;
    logic [IW-1:0]   ipld;
    logic [IW-1:0]   wpld;
    logic            pv;
    logic [1:0]      ps;
    logic            av;
    logic [1:0]      at;
  } beat_t;

  typedef struct packed {
    logic [RW-1:0] row;
    logic [OW-1:0] data;
  } res_t;

  beat_t beat_q[$];
  res_t  res_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  bit    rdy_rand = 0, res_rand = 0;
  int    stall_row = -1, stall_left = 0;
  bit    job_i16, job_pv, job_av;
  logic [1:0] job_ps, job_at;

  always #5 clk = ~clk;

  lsu_mxu_drv dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_clr(cmd_clr), .cmd_int16(cmd_int16),
    .cmd_pool_vld(cmd_pool_vld), .cmd_pool_size(cmd_pool_size),
    .cmd_act_vld(cmd_act_vld), .cmd_act_type(cmd_act_type),
    .opd_vld(opd_vld), .opd_rdy(opd_rdy), .opd_iram_pld(opd_iram_pld), .opd_wram_pld(opd_wram_pld),
    .lsu_top_vld(lsu_top_vld), .lsu_top_clr(lsu_top_clr),
    .lsu_top_iram_vld(lsu_top_iram_vld), .lsu_top_iram_pld(lsu_top_iram_pld),
    .lsu_top_wram_vld(lsu_top_wram_vld), .lsu_top_wram_pld(lsu_top_wram_pld),
    .lsu_top_pool_vld(lsu_top_pool_vld), .lsu_top_pool_size(lsu_top_pool_size),
    .lsu_top_act_vld(lsu_top_act_vld), .lsu_top_act_type(lsu_top_act_type),
    .lsu_top_wfi(lsu_top_wfi), .top_lsu_rdy(top_lsu_rdy), .top_lsu_data_rdy(top_lsu_data_rdy),
    .top_lsu_int8_row0_data(r8[0]),   .top_lsu_int8_row1_data(r8[1]),
    .top_lsu_int8_row2_data(r8[2]),   .top_lsu_int8_row3_data(r8[3]),
    .top_lsu_int8_row4_data(r8[4]),   .top_lsu_int8_row5_data(r8[5]),
    .top_lsu_int8_row6_data(r8[6]),   .top_lsu_int8_row7_data(r8[7]),
    .top_lsu_int8_row8_data(r8[8]),   .top_lsu_int8_row9_data(r8[9]),
    .top_lsu_int8_row10_data(r8[10]), .top_lsu_int8_row11_data(r8[11]),
    .top_lsu_int8_row12_data(r8[12]), .top_lsu_int8_row13_data(r8[13]),
    .top_lsu_int8_row14_data(r8[14]), .top_lsu_int8_row15_data(r8[15]),
    .top_lsu_int16_row0_data(r16[0]),   .top_lsu_int16_row1_data(r16[1]),
    .top_lsu_int16_row2_data(r16[2]),   .top_lsu_int16_row3_data(r16[3]),
    .top_lsu_int16_row4_data(r16[4]),   .top_lsu_int16_row5_data(r16[5]),
    .top_lsu_int16_row6_data(r16[6]),   .top_lsu_int16_row7_data(r16[7]),
    .top_lsu_int16_row8_data(r16[8]),   .top_lsu_int16_row9_data(r16[9]),
    .top_lsu_int16_row10_data(r16[10]), .top_lsu_int16_row11_data(r16[11]),
    .top_lsu_int16_row12_data(r16[12]), .top_lsu_int16_row13_data(r16[13]),
    .top_lsu_int16_row14_data(r16[14]), .top_lsu_int16_row15_data(r16[15]),
    .res_vld(res_vld), .res_rdy(res_rdy), .res_row(res_row), .res_data(res_data)
  );

  function automatic logic [IW-1:0] rand_iw();
    logic [IW-1:0] v;
    for (int i = 0; i < IW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [OW-1:0] rand_ow();
    logic [OW-1:0] v;
    for (int i = 0; i < OW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic beat_t cur_beat();
    beat_t b;
    b.clr = lsu_top_clr;       b.isel = lsu_top_iram_vld; b.wsel = lsu_top_wram_vld;
    b.ipld = lsu_top_iram_pld; b.wpld = lsu_top_wram_pld;
    b.pv = lsu_top_pool_vld;   b.ps = lsu_top_pool_size;
    b.av = lsu_top_act_vld;    b.at = lsu_top_act_type;
    return b;
  endfunction

  task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: event never occurred / unexpected", name);
  endtask

  // monitor: pops the scoreboard on every transfer and checks beats hold while stalled
  beat_t held;
  bit    stalled = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 0;
    end else begin
      if (stalled)
        checkOutput("hold_stable", {lsu_top_vld, cur_beat()}, {1'b1, held});
      if (lsu_top_vld && top_lsu_rdy) begin
        if (beat_q.size() == 0) failNow("unexpected_top_beat");
        else checkOutput("top_beat", cur_beat(), beat_q.pop_front());
      end
      stalled = lsu_top_vld && !top_lsu_rdy;
      held    = cur_beat();
      if (res_vld && res_rdy) begin
        if (res_q.size() == 0) failNow("unexpected_res_row");
        else checkOutput("res_row_data", {res_row, res_data}, res_q.pop_front());
      end
    end
  end

  // downstream ready generators, with a one-shot 3-cycle stall on a chosen row
  always @(posedge clk) begin
    #1;
    if (stall_left > 0) begin
      top_lsu_rdy = 1'b0;
      stall_left--;
    end else if (stall_row >= 0 && lsu_top_vld && lsu_top_iram_vld == (16'(1) << stall_row)) begin
      top_lsu_rdy = 1'b0;
      stall_left  = 2;
      stall_row   = -1;
    end else begin
      top_lsu_rdy = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    res_rdy = res_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic checkReset(input string tag);
    checkOutput({tag, "_cmd_rdy"}, 512'(cmd_rdy), 512'd1);
    checkOutput({tag, "_ctrl"},
      512'({opd_rdy, lsu_top_vld, lsu_top_clr, lsu_top_iram_vld, lsu_top_wram_vld,
            lsu_top_pool_vld, lsu_top_pool_size, lsu_top_act_vld, lsu_top_act_type,
            lsu_top_wfi, res_vld, res_row}), 512'd0);
    checkOutput({tag, "_plds"}, 512'({lsu_top_iram_pld, lsu_top_wram_pld}), 512'd0);
    checkOutput({tag, "_res_data"}, 512'(res_data), 512'd0);
  endtask

  task automatic sendCmd(input bit clr);
    cmd_clr = clr; cmd_int16 = job_i16;
    cmd_pool_vld = job_pv; cmd_pool_size = job_ps;
    cmd_act_vld = job_av; cmd_act_type = job_at;
    cmd_vld = 1'b1;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (cmd_rdy) break;
      if (t > 2000) begin failNow("cmd_accept_timeout"); cmd_vld = 1'b0; return; end
    end
    @(posedge clk); #1;
    cmd_vld = 1'b0;
  endtask

  task automatic sendRow(input int k, input logic [IW-1:0] ip, input logic [IW-1:0] wp);
    beat_t b;
    opd_vld = 1'b0;
    if (rdy_rand) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    b.clr = 1'b0; b.isel = 16'(1) << k; b.wsel = 16'(1) << k; b.ipld = ip; b.wpld = wp;
    b.pv = (k == NROW-1) ? job_pv : 1'b0; b.ps = (k == NROW-1) ? job_ps : 2'd0;
    b.av = (k == NROW-1) ? job_av : 1'b0; b.at = (k == NROW-1) ? job_at : 2'd0;
    beat_q.push_back(b);
    opd_vld = 1'b1; opd_iram_pld = ip; opd_wram_pld = wp;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (opd_rdy) break;
      if (t > 2000) begin failNow("opd_accept_timeout"); opd_vld = 1'b0; return; end
    end
    @(posedge clk); #1;
    opd_vld = 1'b0;
  endtask

  task automatic applyStimulus(input bit i16, input int stall, input bit early,
                               input int abort_row, input bit patterned);
    logic [IW-1:0] ip, wp;
    res_t r;
    job_i16 = i16;
    job_pv  = patterned ? 1'b1 : 1'($urandom_range(0, 1));
    job_av  = patterned ? 1'b1 : 1'($urandom_range(0, 1));
    job_ps  = 2'($urandom_range(1, 3));
    job_at  = 2'($urandom_range(1, 3));
    sendCmd(1'b0);
    stall_row = stall;
    for (int k = 0; k < NROW; k++) begin
      ip = patterned ? {16{8'(k)}} : rand_iw();
      wp = patterned ? ({16{8'(k)}} ^ {16{8'hA5}}) : rand_iw();
      sendRow(k, ip, wp);
      if (early && k == 3) begin
        for (int n = 0; n < NROW; n++) begin r8[n] = rand_iw(); r16[n] = rand_ow(); end
        top_lsu_data_rdy = 1'b1;
        @(posedge clk); #1;
        top_lsu_data_rdy = 1'b0;
      end
      if (k == abort_row) begin
        rst_n = 1'b0;
        beat_q.delete(); res_q.delete();
        stall_left = 0; stall_row = -1;
        @(negedge clk);
        checkReset("abort");
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
    end
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (lsu_top_wfi) break;
      if (t > 2000) begin failNow("wfi_timeout"); return; end
    end
    checkOutput("wfi_after_feed", 512'(lsu_top_wfi), 512'd1);
    checkOutput("all_beats_seen", 512'(beat_q.size()), 512'd0);
    @(posedge clk); #1;
    for (int n = 0; n < NROW; n++) begin
      r8[n]  = rand_iw();
      r16[n] = patterned ? OW'(n * 17) : rand_ow();
      r.row  = RW'(n);
      r.data = i16 ? r16[n] : OW'(r8[n]);
      res_q.push_back(r);
    end
    top_lsu_data_rdy = 1'b1;
    @(posedge clk); #1;
    top_lsu_data_rdy = 1'b0;
    for (int n = 0; n < NROW; n++) begin r8[n] = rand_iw(); r16[n] = rand_ow(); end
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (res_q.size() == 0 && cmd_rdy) break;
      if (t > 2000) begin failNow("drain_timeout"); return; end
    end
    @(posedge clk); #1;
  endtask

  task automatic clearJob();
    beat_t b;
    b = '0;
    b.clr = 1'b1;
    beat_q.push_back(b);
    sendCmd(1'b1);
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (lsu_top_vld && top_lsu_rdy) break;
      if (t > 2000) begin failNow("clr_beat_timeout"); return; end
    end
    @(negedge clk);
    checkOutput("clr_cmd_rdy_back", 512'(cmd_rdy), 512'd1);
    checkOutput("clr_no_res", 512'(res_vld), 512'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cmd_vld = 0; cmd_clr = 0; cmd_int16 = 0; cmd_pool_vld = 0; cmd_pool_size = 0;
    cmd_act_vld = 0; cmd_act_type = 0;
    opd_vld = 0; opd_iram_pld = '0; opd_wram_pld = '0;
    top_lsu_rdy = 1'b1; top_lsu_data_rdy = 1'b0; res_rdy = 1'b1;
    for (int n = 0; n < NROW; n++) begin r8[n] = rand_iw(); r16[n] = rand_ow(); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkReset("por");
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] job 1: int8, patterned rows, ready always high");
    applyStimulus(1'b0, -1, 1'b0, -1, 1'b1);
    $display("[TB] job 2: int16, 3-cycle stall on row 5, res_rdy toggling");
    res_rand = 1;
    applyStimulus(1'b1, 5, 1'b0, -1, 1'b1);
    $display("[TB] job 3: clear only");
    clearJob();
    $display("[TB] job 4: random, early data_rdy during feed");
    rdy_rand = 1;
    applyStimulus(1'b0, -1, 1'b1, -1, 1'b0);
    $display("[TB] job 5: reset at row 9, then restart");
    applyStimulus(1'b1, -1, 1'b0, 9, 1'b0);
    applyStimulus(1'b0, -1, 1'b0, -1, 1'b1);
    for (int j = 0; j < 4; j++) begin
      if ($urandom_range(0, 3) == 0) clearJob();
      applyStimulus(1'($urandom_range(0, 1)), -1, 1'($urandom_range(0, 1)), -1, 1'b0);
    end

    checkOutput("final_beat_q_empty", 512'(beat_q.size()), 512'd0);
    checkOutput("final_res_q_empty", 512'(res_q.size()), 512'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
